// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: state encoding,
// frame sync byte, LED patterns and small state-decoding helpers.
package loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_SYNC   = 4'd1,
      ST_CNT_H  = 4'd2,
      ST_CNT_L  = 4'd3,
      ST_DATA_H = 4'd4,
      ST_DATA_L = 4'd5,
      ST_WRITE  = 4'd6,
      ST_CHK    = 4'd7,
      ST_DONE   = 4'd8,
      ST_ERROR  = 4'd9
   } state_t;

   localparam logic [7:0] SYNC_BYTE  = 8'hA5;

   localparam logic [7:0] LED_IDLE   = 8'h00;
   localparam logic [7:0] LED_SYNC   = 8'h01;
   localparam logic [7:0] LED_CNT    = 8'h02;
   localparam logic [7:0] LED_DATA   = 8'h04;
   localparam logic [7:0] LED_WRITE  = 8'h08;
   localparam logic [7:0] LED_CHK    = 8'h10;
   localparam logic [7:0] LED_DONE   = 8'h80;
   localparam logic [7:0] LED_ERROR  = 8'hF0;

   // LED pattern shown for a given state.
   function automatic logic [7:0] status_of(input state_t s);
      logic [7:0] led;
      case (s)
         ST_IDLE:            led = LED_IDLE;
         ST_SYNC:            led = LED_SYNC;
         ST_CNT_H, ST_CNT_L: led = LED_CNT;
         ST_DATA_H, ST_DATA_L: led = LED_DATA;
         ST_WRITE:           led = LED_WRITE;
         ST_CHK:             led = LED_CHK;
         ST_DONE:            led = LED_DONE;
         ST_ERROR:           led = LED_ERROR;
         default:            led = LED_ERROR;
      endcase
      return led;
   endfunction

   // States in which the inter-byte idle timeout is running.
   function automatic logic is_timed(input state_t s);
      return (s inside {ST_CNT_H, ST_CNT_L, ST_DATA_H, ST_DATA_L, ST_WRITE, ST_CHK});
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle timer. Reloaded with TIMEOUT by 'load'; every 'tick'
// consumes one idle cycle. 'expire' flags the tick that uses up the last
// allowed idle cycle, so the owner can leave on that same edge.
module loader_timeout #(
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] remain_reg;

   // Down-counter of idle cycles still allowed; saturates at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remain_reg <= CW'(TIMEOUT);
      end else if (load) begin
         remain_reg <= CW'(TIMEOUT);
      end else if (tick && (remain_reg != '0)) begin
         remain_reg <= remain_reg - CW'(1);
      end
   end

   // Zero is included so a timer that ran out while ignored still fires.
   assign expire = tick && (remain_reg <= CW'(1));

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: hunts for the sync byte, reads a big-endian word
// count, assembles 16-bit words from byte pairs, writes them to program
// memory and releases the CPU only after the XOR checksum matches.
module prog_loader
   import loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADR = 16'h0000,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned TIMEOUT  = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        start,
   output logic [15:0] mem_adr,
   output logic [15:0] mem_din,
   output logic        mw_en,
   output logic        cpu_hold,
   output logic        busy,
   output logic        err,
   output logic [7:0]  status
);

   state_t      state_reg;
   logic [7:0]  cnt_hi_reg;
   logic [15:0] word_cnt_reg;
   logic [15:0] idx_reg;
   logic [7:0]  hi_reg;
   logic [7:0]  xor_reg;
   logic [7:0]  hold_reg;
   logic        hold_valid_reg;
   logic        mw_en_reg;
   logic [15:0] mem_adr_reg;
   logic [15:0] mem_din_reg;

   logic        byte_avail;
   logic [7:0]  byte_val;
   logic [15:0] cnt_value;
   logic        cnt_bad;
   logic        tmo_load;
   logic        tmo_tick;
   logic        tmo_expire;

   // A byte caught during WRITE is replayed from the holding register on
   // the following cycle; only DATA_H and CHK can follow WRITE.
   assign byte_avail = rx_valid | hold_valid_reg;
   assign byte_val   = hold_valid_reg ? hold_reg : rx_data;

   assign cnt_value  = {cnt_hi_reg, rx_data};
   assign cnt_bad    = (cnt_value == 16'd0) || (32'(cnt_value) > DEPTH);

   // Any accepted byte, or any untimed state, restarts the idle window.
   assign tmo_load   = byte_avail || !is_timed(state_reg);
   assign tmo_tick   = !tmo_load;

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .load   (tmo_load),
      .tick   (tmo_tick),
      .expire (tmo_expire)
   );

   // Frame FSM with word assembly, checksum accumulation and write strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         cnt_hi_reg     <= '0;
         word_cnt_reg   <= '0;
         idx_reg        <= '0;
         hi_reg         <= '0;
         xor_reg        <= '0;
         hold_reg       <= '0;
         hold_valid_reg <= 1'b0;
         mw_en_reg      <= 1'b0;
         mem_adr_reg    <= BASE_ADR;
         mem_din_reg    <= '0;
      end else begin
         mw_en_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               // A byte on the same edge as start is deliberately dropped.
               if (start) begin
                  state_reg      <= ST_SYNC;
                  idx_reg        <= '0;
                  xor_reg        <= '0;
                  hold_valid_reg <= 1'b0;
               end
            end
            ST_SYNC: begin
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state_reg <= ST_CNT_H;
               end
            end
            ST_CNT_H: begin
               if (rx_valid) begin
                  cnt_hi_reg <= rx_data;
                  state_reg  <= ST_CNT_L;
               end else if (tmo_expire) begin
                  state_reg <= ST_ERROR;
               end
            end
            ST_CNT_L: begin
               if (rx_valid) begin
                  word_cnt_reg <= cnt_value;
                  state_reg    <= cnt_bad ? ST_ERROR : ST_DATA_H;
               end else if (tmo_expire) begin
                  state_reg <= ST_ERROR;
               end
            end
            ST_DATA_H: begin
               if (byte_avail) begin
                  hi_reg         <= byte_val;
                  xor_reg        <= xor_reg ^ byte_val;
                  hold_valid_reg <= 1'b0;
                  state_reg      <= ST_DATA_L;
               end else if (tmo_expire) begin
                  state_reg <= ST_ERROR;
               end
            end
            ST_DATA_L: begin
               if (rx_valid) begin
                  xor_reg     <= xor_reg ^ rx_data;
                  mem_adr_reg <= BASE_ADR + idx_reg;
                  mem_din_reg <= {hi_reg, rx_data};
                  mw_en_reg   <= 1'b1;
                  state_reg   <= ST_WRITE;
               end else if (tmo_expire) begin
                  state_reg <= ST_ERROR;
               end
            end
            ST_WRITE: begin
               idx_reg <= idx_reg + 16'd1;
               if (rx_valid) begin
                  hold_reg       <= rx_data;
                  hold_valid_reg <= 1'b1;
               end
               if (tmo_expire) begin
                  state_reg <= ST_ERROR;
               end else if ((idx_reg + 16'd1) == word_cnt_reg) begin
                  state_reg <= ST_CHK;
               end else begin
                  state_reg <= ST_DATA_H;
               end
            end
            ST_CHK: begin
               if (byte_avail) begin
                  hold_valid_reg <= 1'b0;
                  state_reg      <= (byte_val == xor_reg) ? ST_DONE : ST_ERROR;
               end else if (tmo_expire) begin
                  state_reg <= ST_ERROR;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign mw_en    = mw_en_reg;
   assign mem_adr  = mem_adr_reg;
   assign mem_din  = mem_din_reg;
   assign cpu_hold = (state_reg != ST_DONE);
   assign busy     = (state_reg inside {ST_SYNC, ST_CNT_H, ST_CNT_L, ST_DATA_H,
                                        ST_DATA_L, ST_WRITE, ST_CHK});
   assign err      = (state_reg == ST_ERROR);
   assign status   = status_of(state_reg);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are driven byte by byte and the
// write strobes, state LEDs and CPU hold are compared to hand-computed values.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        start = 1'b0;
   logic [15:0] mem_adr;
   logic [15:0] mem_din;
   logic        mw_en;
   logic        cpu_hold;
   logic        busy;
   logic        err;
   logic [7:0]  status;

   int checks = 0;
   int failures = 0;

   logic [15:0] wr_adr_q[$];
   logic [15:0] wr_din_q[$];
   logic [7:0]  frame_q[$];

   always #5 clk = ~clk;

   prog_loader #(
      .BASE_ADR (16'h0000),
      .DEPTH    (256),
      .TIMEOUT  (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .start    (start),
      .mem_adr  (mem_adr),
      .mem_din  (mem_din),
      .mw_en    (mw_en),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .err      (err),
      .status   (status)
   );

   // Log every write strobe, sampled mid-cycle.
   always @(negedge clk) begin
      if (mw_en) begin
         wr_adr_q.push_back(mem_adr);
         wr_din_q.push_back(mem_din);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input int gap);
      foreach (frame_q[i]) send_byte(frame_q[i], gap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_adr_q.delete();
      wr_din_q.delete();
   endtask

   initial begin
      logic [7:0] chk;

      // ---- reset state ----
      repeat (3) tick();
      check_val("rst_status", 32'(status), 32'h00);
      check_val("rst_hold", 32'(cpu_hold), 32'h1);
      check_val("rst_mw_en", 32'(mw_en), 32'h0);
      check_val("rst_adr", 32'(mem_adr), 32'h0000);
      check_val("rst_din", 32'(mem_din), 32'h0000);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_err", 32'(err), 32'h0);
      reset = 1'b1;
      tick();

      // ---- start and a byte on the same edge: byte ignored ----
      start = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'hA5;
      tick();
      start = 1'b0;
      rx_valid = 1'b0;
      check_val("start_byte_status", 32'(status), 32'h01);
      check_val("start_busy", 32'(busy), 32'h1);

      // ---- single word ----
      clear_log();
      frame_q = '{8'hA5, 8'h00, 8'h01, 8'h7A, 8'h40, 8'h3A};
      send_frame(3);
      check_val("single_status", 32'(status), 32'h80);
      check_val("single_hold", 32'(cpu_hold), 32'h0);
      check_val("single_busy", 32'(busy), 32'h0);
      check_val("single_nwr", 32'(wr_adr_q.size()), 32'd1);
      check_val("single_adr", 32'(wr_adr_q[0]), 32'h0000);
      check_val("single_din", 32'(wr_din_q[0]), 32'h7A40);

      // ---- restart from DONE raises hold again; bad checksum ----
      clear_log();
      pulse_start();
      check_val("restart_hold", 32'(cpu_hold), 32'h1);
      check_val("restart_status", 32'(status), 32'h01);
      frame_q = '{8'hA5, 8'h00, 8'h01, 8'h7A, 8'h40, 8'h3B};
      send_frame(3);
      check_val("badchk_status", 32'(status), 32'hF0);
      check_val("badchk_err", 32'(err), 32'h1);
      check_val("badchk_hold", 32'(cpu_hold), 32'h1);
      check_val("badchk_nwr", 32'(wr_adr_q.size()), 32'd1);
      check_val("badchk_din", 32'(wr_din_q[0]), 32'h7A40);

      // ---- sync hunting; a byte arrives during WRITE (held) ----
      clear_log();
      pulse_start();
      frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h12};
      send_frame(2);
      send_byte(8'h34, 0);
      send_byte(8'h56, 2);
      send_byte(8'h78, 2);
      send_byte(8'h08, 2);
      check_val("hunt_status", 32'(status), 32'h80);
      check_val("hunt_nwr", 32'(wr_adr_q.size()), 32'd2);
      check_val("hunt_adr0", 32'(wr_adr_q[0]), 32'h0000);
      check_val("hunt_din0", 32'(wr_din_q[0]), 32'h1234);
      check_val("hunt_adr1", 32'(wr_adr_q[1]), 32'h0001);
      check_val("hunt_din1", 32'(wr_din_q[1]), 32'h5678);

      // ---- word count zero ----
      clear_log();
      pulse_start();
      frame_q = '{8'hA5, 8'h00, 8'h00};
      send_frame(2);
      check_val("n0_status", 32'(status), 32'hF0);
      check_val("n0_nwr", 32'(wr_adr_q.size()), 32'd0);

      // ---- word count DEPTH+1 ----
      pulse_start();
      frame_q = '{8'hA5, 8'h01, 8'h01};
      send_frame(2);
      check_val("n257_status", 32'(status), 32'hF0);
      check_val("n257_nwr", 32'(wr_adr_q.size()), 32'd0);

      // ---- word count exactly DEPTH ----
      clear_log();
      pulse_start();
      frame_q = '{8'hA5, 8'h01, 8'h00};
      send_frame(1);
      chk = 8'h00;
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i), 1);
         send_byte(8'h5A, 1);
         chk = chk ^ 8'(i) ^ 8'h5A;
      end
      send_byte(chk, 1);
      check_val("n256_status", 32'(status), 32'h80);
      check_val("n256_nwr", 32'(wr_adr_q.size()), 32'd256);
      check_val("n256_last_adr", 32'(wr_adr_q[$]), 32'h00FF);
      check_val("n256_last_din", 32'(wr_din_q[$]), 32'hFF5A);

      // ---- timeout after 16 idle cycles ----
      clear_log();
      pulse_start();
      send_byte(8'hA5, 2);
      send_byte(8'h00, 0);
      repeat (15) tick();
      check_val("tmo_before", 32'(status), 32'h02);
      tick();
      check_val("tmo_status", 32'(status), 32'hF0);
      check_val("tmo_err", 32'(err), 32'h1);

      // ---- reset mid-frame after three data bytes ----
      clear_log();
      pulse_start();
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
      send_frame(2);
      reset = 1'b0;
      #1;
      check_val("midrst_status", 32'(status), 32'h00);
      check_val("midrst_hold", 32'(cpu_hold), 32'h1);
      tick();
      reset = 1'b1;
      repeat (20) tick();
      check_val("midrst_nwr", 32'(wr_adr_q.size()), 32'd1);
      check_val("midrst_din0", 32'(wr_din_q[0]), 32'h1122);
      clear_log();
      pulse_start();
      frame_q = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
      send_frame(3);
      check_val("reload_status", 32'(status), 32'h80);
      check_val("reload_hold", 32'(cpu_hold), 32'h0);
      check_val("reload_nwr", 32'(wr_adr_q.size()), 32'd1);
      check_val("reload_din", 32'(wr_din_q[0]), 32'hABCD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the 16-bit RISC processor. It takes bytes from the UART receiver, assembles them into 16-bit instruction words, writes them into program memory through the same memory port the Control Unit reads, and holds the CPU in reset until the image is complete and its checksum is verified. It sits between the UART receiver, program memory and the CPU reset input.

## Interface
- `BASE_ADR`, default 16'h0000: memory address of the first loaded word.
- `DEPTH`, default 256: maximum number of words accepted.
- `TIMEOUT`, default 1_000_000: idle clock cycles allowed between bytes once a frame has started.
- `clk  in  1`: system clock; the only clock.
- `reset  in  1`: asynchronous, active-low reset.
- `rx_data  in  8`: received byte. Valid only while `rx_valid` is 1.
- `rx_valid  in  1`: one-cycle strobe, one per received byte.
- `start  in  1`: level input; arms the loader from IDLE, DONE or ERROR.
- `mem_adr  out  16`: memory write address.
- `mem_din  out  16`: memory write data.
- `mw_en  out  1`: one-cycle memory write strobe.
- `cpu_hold  out  1`: drives the CPU reset. It is 1 whenever the state is not DONE.
- `busy  out  1`: 1 in states SYNC through CHK.
- `err  out  1`: 1 in state ERROR.
- `status  out  8`: LED pattern for the current state.

## Operation
- Frame format, in byte order:
  - sync byte 8'hA5
  - CNT_H, CNT_L: word count N, big-endian
  - 2N data bytes, high byte first for each word
  - CHK: XOR of all 2N data bytes
- States and transitions:
  - IDLE: on `start`=1 → SYNC.
  - SYNC: waits for a byte. 8'hA5 → CNT_H. Any other byte is discarded and the state stays SYNC; this state has no timeout.
  - CNT_H: on a byte → CNT_L.
  - CNT_L: on a byte → DATA_H, but → ERROR if N=0 or N>DEPTH.
  - DATA_H: on a byte, latch it as the high byte → DATA_L.
  - DATA_L: on a byte → WRITE.
  - WRITE: lasts one cycle.
    - Assert `mw_en`=1 with `mem_adr`=BASE_ADR+idx and `mem_din`={hi,lo}.
    - Increment idx.
    - → CHK if idx reaches N, otherwise → DATA_H.
  - CHK: on a byte → DONE if the byte equals the running XOR, else → ERROR.
  - DONE: `cpu_hold`=0. On `start`=1 → SYNC, which reloads the image and asserts `cpu_hold` again.
  - ERROR: on `start`=1 → SYNC.
- Registers cleared on entry to SYNC: idx, running XOR, timeout counter.
- Timeout: in states CNT_H through CHK, the counter increments every cycle without `rx_valid`. A byte clears it. Reaching TIMEOUT → ERROR.
- A byte arriving while in WRITE is not lost. It is buffered in a 1-entry holding register and consumed in DATA_H on the next cycle. Because of the UART byte rate, a second byte cannot arrive before then.
- Address arithmetic is 16-bit and wraps modulo 2^16. No error is raised on wrap.
- `status` pattern per state:
  - IDLE 8'h00
  - SYNC 8'h01
  - CNT 8'h02
  - DATA 8'h04
  - WRITE 8'h08
  - CHK 8'h10
  - DONE 8'h80
  - ERROR 8'hF0
- Reset values: state IDLE, `cpu_hold`=1, `mw_en`=0, `mem_adr`=BASE_ADR, `mem_din`=0, `busy`=0, `err`=0, `status`=8'h00.

## Timing
- All outputs are registered or decoded from registered state (Moore). No input reaches an output combinationally.
- The `rx_valid` byte is sampled on the clock edge where `rx_valid`=1. The state advances on that same edge.
- `mw_en` is high for exactly one cycle per word: the cycle after the DATA_L byte edge. `mem_adr` and `mem_din` are stable during that cycle.
- `cpu_hold` falls on the edge that enters DONE. It rises on the edge that leaves DONE.
- Reset asserted mid-frame: immediately returns to IDLE and `cpu_hold`=1. Memory keeps any words already written.
- `start` and `rx_valid` on the same edge in IDLE: only the state change to SYNC takes effect. The byte is ignored.

## Structure
- Shared package `loader_pkg` holds:
  - the state encoding, 4-bit
  - SYNC_BYTE = 8'hA5
  - the `status` LED constants
- One sub-module, `loader_timeout`: a down-counter with load and expire outputs, parameterised by TIMEOUT.
- The FSM, the word assembler and the XOR accumulator stay in `prog_loader`.

## Test plan
- **Single word.** With BASE_ADR=0, send A5,00,01,7A,40,3A → exactly one `mw_en` pulse at adr 0 with din 16'h7A40, then DONE, `cpu_hold`=0, `status`=8'h80.
- **Bad checksum.** Same frame with final byte 3B → the word is still written, ERROR, `err`=1, `cpu_hold`=1.
- **Sync hunting.** Send 00,FF,A5,00,02 followed by 4 data bytes and a correct checksum → garbage ignored, writes at adr 0 and 1, DONE.
- **Count out of range.** N=0 → ERROR after CNT_L, no `mw_en`. N=DEPTH+1 → ERROR.
- **Timeout.** With TIMEOUT=16, send A5,00 then stall → ERROR 16 cycles after the last byte.
- **Reset mid-frame.** Assert reset after 3 data bytes → IDLE, `cpu_hold`=1, no further writes. Then `start` and a full frame → DONE.
